// File: rtl/line_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// line_bus_arbiter_if
//   Bundles every handshake/bus signal of the line bus arbiter. It carries the
//   N requesting masters on one side and the single unified line memory port
//   on the other.
//
//   Modports
//     slave  : arbiter view. Takes master requests and memory responses.
//              Drives master completions and memory requests.
//     master : environment view (the cache masters together with the line
//              memory). Drives requests and memory responses.
//
//   Signals (N = N_MASTERS)
//     m_rd_req_i   [N]      per-master refill request (level)
//     m_wb_req_i   [N]      per-master write-back request (level)
//     m_rd_addr_i  [N*AW]   refill address, slice i = [i*AW +: AW]
//     m_wb_addr_i  [N*AW]   write-back address
//     m_wb_data_i  [N*LW]   write-back line
//     m_rdata_o    [LW]     shared refill line, valid with m_ready_o
//     m_ready_o    [N]      one-hot single-cycle completion pulse
//     m_err_o               completion was caused by a timeout
//     mem_rd_req_o          memory read request
//     mem_wb_req_o          memory write request
//     mem_addr_o   [AW]     memory address
//     mem_wdata_o  [LW]     memory write line
//     mem_rdata_i  [LW]     memory read line, valid with mem_ready_i
//     mem_ready_i           memory single-cycle completion pulse
// ---------------------------------------------------------------------------
interface line_bus_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int AW        = 32,
  parameter int LW        = 128
);
  logic [N_MASTERS-1:0]    m_rd_req_i;
  logic [N_MASTERS-1:0]    m_wb_req_i;
  logic [N_MASTERS*AW-1:0] m_rd_addr_i;
  logic [N_MASTERS*AW-1:0] m_wb_addr_i;
  logic [N_MASTERS*LW-1:0] m_wb_data_i;
  logic [LW-1:0]           m_rdata_o;
  logic [N_MASTERS-1:0]    m_ready_o;
  logic                    m_err_o;
  logic                    mem_rd_req_o;
  logic                    mem_wb_req_o;
  logic [AW-1:0]           mem_addr_o;
  logic [LW-1:0]           mem_wdata_o;
  logic [LW-1:0]           mem_rdata_i;
  logic                    mem_ready_i;

  modport slave (
    input  m_rd_req_i, m_wb_req_i, m_rd_addr_i, m_wb_addr_i, m_wb_data_i,
    input  mem_rdata_i, mem_ready_i,
    output m_rdata_o, m_ready_o, m_err_o,
    output mem_rd_req_o, mem_wb_req_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output m_rd_req_i, m_wb_req_i, m_rd_addr_i, m_wb_addr_i, m_wb_data_i,
    output mem_rdata_i, mem_ready_i,
    input  m_rdata_o, m_ready_o, m_err_o,
    input  mem_rd_req_o, mem_wb_req_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/line_bus_arbiter.sv
// ---------------------------------------------------------------------------
// line_bus_arbiter
//   Merges cache-line requests from N_MASTERS masters onto one line memory
//   port. Each transaction is a write-back, a refill, or a fused
//   write-back-then-refill. It ends with one m_ready_o pulse to the granted
//   master. Arbitration is either round-robin or fixed priority, where the
//   lowest index wins. An optional per-phase timeout aborts a stuck memory
//   phase and completes the transaction with m_err_o.
//
//   Parameters
//     N_MASTERS  number of masters (1..8)
//     AW / LW    address / line width
//     RR_MODE    1 = round-robin, 0 = fixed priority
//     TIMEOUT    max cycles per memory phase without mem_ready_i, 0 = off
//
//   Ports
//     clk        rising-edge clock
//     rst_n      synchronous active-low reset
//     bus        line_bus_arbiter_if.slave (all master and memory signals)
//
//   Timing: a request seen in IDLE raises the memory request on the next
//   cycle. A mem_ready_i at cycle k gives m_ready_o at cycle k+1. Every
//   output is registered.
// ---------------------------------------------------------------------------
module line_bus_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int AW        = 32,
  parameter int LW        = 128,
  parameter int RR_MODE   = 1,
  parameter int TIMEOUT   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  line_bus_arbiter_if.slave    bus
);

  localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WB,
    S_RD,
    S_DONE
  } state_t;

  state_t               state;
  logic [GW-1:0]        grant_q;
  logic [GW-1:0]        rr_ptr;
  logic                 rd_flag_q;
  logic [AW-1:0]        rd_addr_q;
  logic [CW-1:0]        tmo_cnt;

  logic [N_MASTERS-1:0] req_vec;
  logic                 any_req;
  logic                 found;
  logic [GW-1:0]        cand;
  logic [GW-1:0]        grant_idx;
  logic [N_MASTERS-1:0] ready_onehot;
  logic                 tmo_expired;

  assign req_vec      = bus.m_rd_req_i | bus.m_wb_req_i;
  assign any_req      = |req_vec;
  assign ready_onehot = N_MASTERS'(1) << grant_q;
  // An expiry in the same cycle as mem_ready_i loses.
  // The ready branch below is therefore tested first.
  assign tmo_expired  = (TIMEOUT > 0) && (tmo_cnt == TMO_LAST);

  // Grant selection. Round-robin scans upward from rr_ptr+1 with wrap-around,
  // so the master granted last has the lowest priority next time. Fixed
  // priority returns the lowest asserted index.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path leaves it holding a value (no latch).
    found     = 1'b0;
    cand      = '0;
    grant_idx = '0;
    if (RR_MODE != 0) begin
      for (int k = 1; k <= N_MASTERS; k++) begin
        cand = GW'((int'(rr_ptr) + k) % N_MASTERS);
        if (!found && req_vec[cand]) begin
          found     = 1'b1;
          grant_idx = cand;
        end
      end
    end else begin
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
        if (req_vec[i]) begin
          grant_idx = GW'(i);
        end
      end
    end
  end

  // A single FSM drives all outputs as registers. Outputs change on the same
  // edge as the state, which gives the cycle-exact latencies described above.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
      state            <= S_IDLE;
      grant_q          <= '0;
      rr_ptr           <= GW'(N_MASTERS - 1);  // master 0 wins first
      rd_flag_q        <= 1'b0;
      rd_addr_q        <= '0;
      tmo_cnt          <= '0;
      bus.m_rdata_o    <= '0;
      bus.m_ready_o    <= '0;
      bus.m_err_o      <= 1'b0;
      bus.mem_rd_req_o <= 1'b0;
      bus.mem_wb_req_o <= 1'b0;
      bus.mem_addr_o   <= '0;
      bus.mem_wdata_o  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // mem_ready_i is deliberately ignored here.
          bus.m_ready_o <= '0;
          bus.m_err_o   <= 1'b0;
          if (any_req) begin
            grant_q   <= grant_idx;
            if (RR_MODE != 0) begin
              rr_ptr <= grant_idx;
            end
            rd_flag_q <= bus.m_rd_req_i[grant_idx];
            rd_addr_q <= bus.m_rd_addr_i[grant_idx*AW +: AW];
            tmo_cnt   <= '0;
            // A write-back always goes first. The refill address is kept for later.
            if (bus.m_wb_req_i[grant_idx]) begin
              state            <= S_WB;
              bus.mem_wb_req_o <= 1'b1;
              bus.mem_addr_o   <= bus.m_wb_addr_i[grant_idx*AW +: AW];
              bus.mem_wdata_o  <= bus.m_wb_data_i[grant_idx*LW +: LW];
            end else begin
              state            <= S_RD;
              bus.mem_rd_req_o <= 1'b1;
              bus.mem_addr_o   <= bus.m_rd_addr_i[grant_idx*AW +: AW];
            end
          end
        end

        S_WB: begin
          if (bus.mem_ready_i) begin
            bus.mem_wb_req_o <= 1'b0;
            bus.mem_wdata_o  <= '0;
            tmo_cnt          <= '0;
            if (rd_flag_q) begin
              // Back-to-back: the write drops and the read rises on the same edge.
              state            <= S_RD;
              bus.mem_rd_req_o <= 1'b1;
              bus.mem_addr_o   <= rd_addr_q;
            end else begin
              state          <= S_DONE;
              bus.mem_addr_o <= '0;
              bus.m_ready_o  <= ready_onehot;
              bus.m_rdata_o  <= '0;  // write-back only: no line to return
            end
          end else if (tmo_expired) begin
            // Abandon the write and any pending refill, then complete with an error.
            state            <= S_DONE;
            bus.mem_wb_req_o <= 1'b0;
            bus.mem_wdata_o  <= '0;
            bus.mem_addr_o   <= '0;
            bus.m_ready_o    <= ready_onehot;
            bus.m_err_o      <= 1'b1;
            bus.m_rdata_o    <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_RD: begin
          if (bus.mem_ready_i) begin
            state            <= S_DONE;
            bus.mem_rd_req_o <= 1'b0;
            bus.mem_addr_o   <= '0;
            bus.m_ready_o    <= ready_onehot;
            bus.m_rdata_o    <= bus.mem_rdata_i;
          end else if (tmo_expired) begin
            state            <= S_DONE;
            bus.mem_rd_req_o <= 1'b0;
            bus.mem_addr_o   <= '0;
            bus.m_ready_o    <= ready_onehot;
            bus.m_err_o      <= 1'b1;
            bus.m_rdata_o    <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_DONE: begin
          // The completion pulse lasts one cycle. m_rdata_o keeps its value.
          state         <= S_IDLE;
          bus.m_ready_o <= '0;
          bus.m_err_o   <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
